// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle MIPS-subset control path.
// Holds ALU operation codes, opcode/funct values, the operand and next-PC
// mux encodings, the sequencer state enum and a funct legality helper.
package alu_pkg;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_SLT = 4'b1001;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct values
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS    = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  // Operand B select
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWR  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_EXEC_R = 4'd6,
    ST_RWB    = 4'd7,
    ST_EXEC_I = 4'd8,
    ST_IWB    = 4'd9,
    ST_BRANCH = 4'd10,
    ST_JUMP   = 4'd11,
    ST_EXC    = 4'd12
  } state_e;

  // True for the R-type funct values the datapath implements.
  function automatic logic funct_legal(input logic [5:0] fn);
    case (fn)
      FN_SLL, FN_SRL, FN_SRA, FN_ADD,
      FN_SUB, FN_AND, FN_OR,  FN_SLT: funct_legal = 1'b1;
      default:                        funct_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle.
// master: the control sequencer (drives strobes/selects, reads IR fields
//         and ALU flags). slave: the datapath side.
interface multicycle_ctrl_if;
  logic [5:0]  Opcode;
  logic [5:0]  Funct;
  logic        Zero;
  logic        Overflow;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        MemtoReg;
  logic        RegDst;
  logic        RegWrite;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  PCSource;
  logic [3:0]  ALUCtrlOut;
  logic        Exception;
  logic [31:0] RetireCount;

  modport master (
    input  Opcode, Funct, Zero, Overflow,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
           ALUCtrlOut, Exception, RetireCount
  );

  modport slave (
    output Opcode, Funct, Zero, Overflow,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
           ALUCtrlOut, Exception, RetireCount
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct -> ALU operation decode.
//   opcode, funct : latched instruction fields
//   alu_code      : 4-bit ALU operation
//   is_shift      : R-type shift (operand A comes from shamt)
//   is_trapping   : ADD/SUB/ADDI, the ops that may trap on overflow
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_code,
  output logic       is_shift,
  output logic       is_trapping
);
  always_comb begin
    alu_code    = ALU_ADD;
    is_shift    = 1'b0;
    is_trapping = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin alu_code = ALU_ADD; is_trapping = 1'b1; end
          FN_SUB: begin alu_code = ALU_SUB; is_trapping = 1'b1; end
          FN_AND: alu_code = ALU_AND;
          FN_OR:  alu_code = ALU_OR;
          FN_SLT: alu_code = ALU_SLT;
          FN_SLL: begin alu_code = ALU_SLL; is_shift = 1'b1; end
          FN_SRL: begin alu_code = ALU_SRL; is_shift = 1'b1; end
          FN_SRA: begin alu_code = ALU_SRA; is_shift = 1'b1; end
          default: alu_code = ALU_ADD;
        endcase
      end
      OP_ADDI: begin alu_code = ALU_ADD; is_trapping = 1'b1; end
      OP_ANDI: alu_code = ALU_AND;
      OP_BEQ:  alu_code = ALU_SUB;
      default: alu_code = ALU_ADD;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control sequencer for the MIPS-subset datapath.
//   Clk, Reset : rising-edge clock, synchronous active-high reset
//   dp         : master side of the datapath bundle (IR fields and ALU
//                flags in; strobes, mux selects, ALU code, Exception,
//                RetireCount out)
// Moore FSM: all outputs other than RetireCount decode from the state
// register and the Opcode/Funct latched when leaving DECODE.
module multicycle_ctrl
  import alu_pkg::*;
#(
  parameter int TRAP_ON_OVERFLOW = 1
) (
  input  logic            Clk,
  input  logic            Reset,
  multicycle_ctrl_if.master dp
);
  localparam logic [3:0] FETCH  = ST_FETCH;
  localparam logic [3:0] DECODE = ST_DECODE;
  localparam logic [3:0] MEMADR = ST_MEMADR;
  localparam logic [3:0] MEMRD  = ST_MEMRD;
  localparam logic [3:0] MEMWR  = ST_MEMWR;
  localparam logic [3:0] MEMWB  = ST_MEMWB;
  localparam logic [3:0] EXEC_R = ST_EXEC_R;
  localparam logic [3:0] RWB    = ST_RWB;
  localparam logic [3:0] EXEC_I = ST_EXEC_I;
  localparam logic [3:0] IWB    = ST_IWB;
  localparam logic [3:0] BRANCH = ST_BRANCH;
  localparam logic [3:0] JUMP   = ST_JUMP;
  localparam logic [3:0] EXC    = ST_EXC;

  logic [3:0]  state, nxt;
  logic [5:0]  op_q, fn_q;
  logic [31:0] rc;
  logic [3:0]  alu_code;
  logic        is_shift, is_trapping;
  logic        ovf_trap, retiring;

  alu_op_decode u_dec (
    .opcode     (op_q),
    .funct      (fn_q),
    .alu_code   (alu_code),
    .is_shift   (is_shift),
    .is_trapping(is_trapping)
  );

  assign ovf_trap = (TRAP_ON_OVERFLOW != 0) && is_trapping && dp.Overflow;

  always_comb begin
    case (state)
      MEMWB, MEMWR, RWB, IWB, BRANCH, JUMP: retiring = 1'b1;
      default:                              retiring = 1'b0;
    endcase
  end

  // Next state. DECODE branches on the live IR; later states use the latch.
  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH:  nxt = DECODE;
      DECODE: begin
        case (dp.Opcode)
          OP_RTYPE:        nxt = funct_legal(dp.Funct) ? EXEC_R : EXC;
          OP_ADDI, OP_ANDI: nxt = EXEC_I;
          OP_LW, OP_SW:    nxt = MEMADR;
          OP_BEQ:          nxt = BRANCH;
          OP_J:            nxt = JUMP;
          default:         nxt = EXC;
        endcase
      end
      MEMADR: nxt = (op_q == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  nxt = MEMWB;
      EXEC_R: nxt = ovf_trap ? EXC : RWB;
      EXEC_I: nxt = ovf_trap ? EXC : IWB;
      default: nxt = FETCH;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= FETCH;
      rc    <= '0;
      op_q  <= '0;
      fn_q  <= '0;
    end else begin
      state <= nxt;
      if (state == DECODE) begin
        op_q <= dp.Opcode;
        fn_q <= dp.Funct;
      end
      if (retiring) rc <= rc + 32'd1;
    end
  end

  // Output decode; everything held at 0 while Reset is high.
  logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, exc;
  logic [1:0] srca, srcb, pcsrc;
  logic [3:0] aluc;

  always_comb begin
    pcw = 1'b0; pcwc = 1'b0; iord = 1'b0; mrd = 1'b0; mwr = 1'b0;
    irw = 1'b0; m2r = 1'b0; rdst = 1'b0; rwr = 1'b0; exc = 1'b0;
    srca = SRCA_PC; srcb = SRCB_RT; pcsrc = PCSRC_ALU; aluc = ALU_AND;
    if (!Reset) begin
      case (state)
        FETCH: begin
          mrd = 1'b1; irw = 1'b1; pcw = 1'b1;
          srca = SRCA_PC; srcb = SRCB_FOUR; aluc = ALU_ADD; pcsrc = PCSRC_ALU;
        end
        DECODE: begin srca = SRCA_PC; srcb = SRCB_IMMSH2; aluc = ALU_ADD; end
        MEMADR: begin srca = SRCA_RS; srcb = SRCB_IMM;    aluc = ALU_ADD; end
        MEMRD:  begin mrd = 1'b1; iord = 1'b1; end
        MEMWR:  begin mwr = 1'b1; iord = 1'b1; end
        MEMWB:  begin rwr = 1'b1; m2r = 1'b1; end
        EXEC_R: begin
          srca = is_shift ? SRCA_SHAMT : SRCA_RS;
          srcb = SRCB_RT;
          aluc = alu_code;
        end
        RWB:    begin rwr = 1'b1; rdst = 1'b1; end
        EXEC_I: begin srca = SRCA_RS; srcb = SRCB_IMM; aluc = alu_code; end
        IWB:    rwr = 1'b1;
        BRANCH: begin
          srca = SRCA_RS; srcb = SRCB_RT; aluc = ALU_SUB;
          pcwc = 1'b1; pcsrc = PCSRC_ALUOUT;
        end
        JUMP:   begin pcw = 1'b1; pcsrc = PCSRC_JUMP; end
        EXC:    begin exc = 1'b1; pcw = 1'b1; pcsrc = PCSRC_EXC; end
        default: ;
      endcase
    end
  end

  assign dp.PCWrite     = pcw;
  assign dp.PCWriteCond = pcwc;
  assign dp.IorD        = iord;
  assign dp.MemRead     = mrd;
  assign dp.MemWrite    = mwr;
  assign dp.IRWrite     = irw;
  assign dp.MemtoReg    = m2r;
  assign dp.RegDst      = rdst;
  assign dp.RegWrite    = rwr;
  assign dp.ALUSrcA     = srca;
  assign dp.ALUSrcB     = srcb;
  assign dp.PCSource    = pcsrc;
  assign dp.ALUCtrlOut  = aluc;
  assign dp.Exception   = exc;
  assign dp.RetireCount = rc;
endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  typedef struct packed {
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw;
    logic [1:0] sa, sb, ps;
    logic [3:0] alu;
    logic exc;
    logic [31:0] rc;
  } out_t;

  typedef struct {
    out_t o;
    int   st;
  } exp_t;

  localparam int F = 0, D = 1, MA = 2, MR = 3, MW = 4, MWB = 5, ER = 6,
                 RWB = 7, EI = 8, IWB = 9, BR = 10, JMP = 11, EXC = 12, RST = 13;

  logic Clk = 1'b0, Reset = 1'b1;
  always #5 Clk = ~Clk;

  multicycle_ctrl_if if0 ();
  multicycle_ctrl_if if1 ();

  multicycle_ctrl #(.TRAP_ON_OVERFLOW(1)) dut0 (.Clk(Clk), .Reset(Reset), .dp(if0.master));
  multicycle_ctrl #(.TRAP_ON_OVERFLOW(0)) dut1 (.Clk(Clk), .Reset(Reset), .dp(if1.master));

  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0, ovf = 1'b0;
  assign if0.Opcode = opcode;  assign if1.Opcode = opcode;
  assign if0.Funct = funct;    assign if1.Funct = funct;
  assign if0.Zero = zero;      assign if1.Zero = zero;
  assign if0.Overflow = ovf;   assign if1.Overflow = ovf;

  out_t act0, act1;
  assign act0 = {if0.PCWrite, if0.PCWriteCond, if0.IorD, if0.MemRead, if0.MemWrite,
                 if0.IRWrite, if0.MemtoReg, if0.RegDst, if0.RegWrite, if0.ALUSrcA,
                 if0.ALUSrcB, if0.PCSource, if0.ALUCtrlOut, if0.Exception, if0.RetireCount};
  assign act1 = {if1.PCWrite, if1.PCWriteCond, if1.IorD, if1.MemRead, if1.MemWrite,
                 if1.IRWrite, if1.MemtoReg, if1.RegDst, if1.RegWrite, if1.ALUSrcA,
                 if1.ALUSrcB, if1.PCSource, if1.ALUCtrlOut, if1.Exception, if1.RetireCount};

  exp_t q0[$], q1[$];
  int n_checks = 0, n_fail = 0;
  logic [31:0] rc0, rc1;
  logic [3:0]  cur_alu;   // hand-picked ALU code for the EXEC state of the current instr
  logic [1:0]  cur_sa;    // hand-picked operand A select for EXEC_R
  bit          done = 0;

  // Expected outputs for one cycle, straight from the per-state output table.
  function automatic out_t exp_out(input int s, input logic [31:0] rc);
    out_t e;
    e = '0;
    e.rc = rc;
    case (s)
      F:   begin e.mr = 1; e.irw = 1; e.pcw = 1; e.sb = 2'b01; e.alu = 4'b0001; end
      D:   begin e.sb = 2'b11; e.alu = 4'b0001; end
      MA:  begin e.sa = 2'b01; e.sb = 2'b10; e.alu = 4'b0001; end
      MR:  begin e.mr = 1; e.iord = 1; end
      MW:  begin e.mw = 1; e.iord = 1; end
      MWB: begin e.rw = 1; e.m2r = 1; end
      ER:  begin e.sa = cur_sa; e.sb = 2'b00; e.alu = cur_alu; end
      RWB: begin e.rw = 1; e.rd = 1; end
      EI:  begin e.sa = 2'b01; e.sb = 2'b10; e.alu = cur_alu; end
      IWB: e.rw = 1;
      BR:  begin e.sa = 2'b01; e.alu = 4'b0010; e.pcwc = 1; e.ps = 2'b01; end
      JMP: begin e.pcw = 1; e.ps = 2'b10; end
      EXC: begin e.exc = 1; e.pcw = 1; e.ps = 2'b11; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic bit retires(input int s);
    return (s == MWB) || (s == MW) || (s == RWB) || (s == IWB) || (s == BR) || (s == JMP);
  endfunction

  // One clock: queue expectations for both DUTs, then advance the retire models.
  task automatic cyc(input int s0, input int s1);
    exp_t e;
    e.o = exp_out(s0, rc0); e.st = s0; q0.push_back(e);
    e.o = exp_out(s1, rc1); e.st = s1; q1.push_back(e);
    @(posedge Clk);
    if (Reset) begin rc0 = 0; rc1 = 0; end
    else begin
      if (retires(s0)) rc0 = rc0 + 1;
      if (retires(s1)) rc1 = rc1 + 1;
    end
    #1;
  endtask

  task automatic both(input int s);
    cyc(s, s);
  endtask

  // Monitor: the DUT presents a full output vector every cycle.
  always @(negedge Clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      n_checks++;
      if (act0 !== e.o) begin
        n_fail++;
        $display("FAIL trap1 state%0d: got %h expected %h", e.st, act0, e.o);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      n_checks++;
      if (act1 !== e.o) begin
        n_fail++;
        $display("FAIL trap0 state%0d: got %h expected %h", e.st, act1, e.o);
      end
    end
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
    end
  end

  initial begin
    cur_alu = 4'b0001; cur_sa = 2'b01;
    Reset = 1;
    @(posedge Clk); #1;
    rc0 = 0; rc1 = 0;
    repeat (3) both(RST);
    Reset = 0;

    // SLT; IR garbage after DECODE must be ignored
    opcode = 6'h00; funct = 6'h2A; cur_alu = 4'b1001; cur_sa = 2'b01;
    both(F); both(D);
    opcode = 6'h3F; funct = 6'h00;
    both(ER); both(RWB);

    // SRA uses shamt operand
    opcode = 6'h00; funct = 6'h03; cur_alu = 4'b1000; cur_sa = 2'b10;
    both(F); both(D); both(ER); both(RWB);

    // LW, SW
    opcode = 6'h23;
    both(F); both(D); both(MA); both(MR); both(MWB);
    opcode = 6'h2B;
    both(F); both(D); both(MA); both(MW);

    // ADDI, then ANDI with Overflow high (ANDI never traps)
    opcode = 6'h08; cur_alu = 4'b0001;
    both(F); both(D); both(EI); both(IWB);
    opcode = 6'h0C; cur_alu = 4'b0000;
    both(F); both(D); ovf = 1; both(EI); ovf = 0; both(IWB);

    // BEQ taken / not taken
    opcode = 6'h04; zero = 1;
    both(F); both(D); both(BR);
    zero = 0;
    both(F); both(D); both(BR);

    // J
    opcode = 6'h02;
    both(F); both(D); both(JMP);

    // ADD with overflow: trap in dut0, normal writeback in dut1
    opcode = 6'h00; funct = 6'h20; cur_alu = 4'b0001; cur_sa = 2'b01;
    both(F); both(D); ovf = 1; both(ER); ovf = 0; cyc(EXC, RWB);

    // SUB without overflow
    funct = 6'h22; cur_alu = 4'b0010;
    both(F); both(D); both(ER); both(RWB);

    // Illegal opcode and illegal R-type funct
    opcode = 6'h3F;
    both(F); both(D); both(EXC);
    opcode = 6'h00; funct = 6'h3F;
    both(F); both(D); both(EXC);

    // Reset while in MEMRD
    opcode = 6'h23;
    both(F); both(D); both(MA);
    Reset = 1; both(RST); both(RST);
    Reset = 0;
    opcode = 6'h02;
    both(F); both(D); both(JMP);
    both(F);

    @(negedge Clk); #1;
    n_checks++;
    if (q0.size() + q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q0.size() + q1.size());
    end
    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control sequencer for the 32-bit MIPS-subset datapath. It is the driving end of the ALU interface. It decodes the fetched instruction's opcode and funct fields, then steps a Moore state machine through fetch, decode, execute, memory and writeback. Each cycle it drives the 4-bit ALU operation code, the operand-mux selects and the register/memory/PC write strobes. It also traps on ALU overflow and illegal opcodes, and counts retired instructions.

## Interface
Parameters:
- TRAP_ON_OVERFLOW, 1, when 1 an ALU Overflow on ADD/SUB/ADDI diverts to the exception state.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high. One clock; reset is synchronous and active-high.
- Opcode  input  6  IR[31:26], valid from DECODE onward.
- Funct  input  6  IR[5:0].
- Zero  input  1  datapath equality flag (A == B) for BEQ.
- Overflow  input  1  ALU overflow/carry bit for the current operation.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite  output  1 each  datapath strobes/selects.
- ALUSrcA  output  2  operand A select: 00 PC, 01 rs, 10 shamt (zero-extended).
- ALUSrcB  output  2  operand B select: 00 rt, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- PCSource  output  2  next-PC select: 00 ALU result, 01 ALUOut register, 10 jump target, 11 exception vector.
- ALUCtrlOut  output  4  ALU operation code.
- Exception  output  1  one-cycle trap pulse.
- RetireCount  output  32  retired-instruction counter.

## Operation
- ALU codes: AND 0000, ADD 0001, SUB 0010, OR 0011, SLL 0101, SRL 0110, SRA 1000, SLT 1001.
- Decode: opcode 0x00 R-type, with funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x00 SLL, 0x02 SRL, 0x03 SRA. Opcode 0x08 ADDI, 0x0C ANDI, 0x23 LW, 0x2B SW, 0x04 BEQ, 0x02 J. Anything else is illegal and goes to EXC.
- States and transitions:
  - FETCH → DECODE.
  - DECODE → MEMADR (LW, SW), EXEC_R, EXEC_I (ADDI, ANDI), BRANCH, JUMP, or EXC.
  - MEMADR → MEMRD (LW) or MEMWR (SW).
  - MEMRD → MEMWB.
  - EXEC_R → RWB. EXEC_I → IWB.
  - MEMWB, MEMWR, RWB, IWB, BRANCH, JUMP and EXC → FETCH.
- Per-state outputs. Anything not listed is 0.
  - FETCH: MemRead, IRWrite, PCWrite, ALUSrcA=00, ALUSrcB=01, ALU ADD, PCSource=00.
  - DECODE: ALUSrcA=00, ALUSrcB=11, ALU ADD (precomputes the branch target).
  - MEMADR: ALUSrcA=01, ALUSrcB=10, ADD.
  - MEMRD: MemRead, IorD.
  - MEMWR: MemWrite, IorD.
  - MEMWB: RegWrite, MemtoReg.
  - EXEC_R: ALUSrcB=00, with ALUSrcA=10 for shifts and 01 otherwise. ALU code comes from funct.
  - RWB: RegWrite, RegDst.
  - EXEC_I: ALUSrcA=01, ALUSrcB=10, ADD or AND.
  - IWB: RegWrite.
  - BRANCH: ALUSrcA=01, ALUSrcB=00, SUB, PCWriteCond, PCSource=01.
  - JUMP: PCWrite, PCSource=10.
  - EXC: Exception, PCWrite, PCSource=11.
- Overflow trap:
  - Applies only when TRAP_ON_OVERFLOW=1 and the instruction is ADD, SUB or ADDI.
  - Overflow is sampled on the clock edge leaving EXEC_R/EXEC_I.
  - If Overflow=1, the next state is EXC instead of RWB/IWB, so no RegWrite occurs.
- Retire counting:
  - RetireCount increments by 1 in MEMWB, MEMWR, RWB, IWB, BRANCH and JUMP, whether or not the branch is taken.
  - It does not increment in EXC.
  - It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset:
  - While Reset=1, every strobe and select output is forced to 0, including ALUCtrlOut and Exception.
  - The edge with Reset=1 loads state FETCH and clears RetireCount to 0.
  - The first fetch happens in the cycle after Reset deasserts.
  - Reset mid-instruction abandons the instruction with no further writes.
- All outputs except RetireCount are combinational decodes of the state register and the latched Opcode/Funct (Moore). RetireCount is registered.
- Cycle counts (FETCH through the last state, inclusive): LW 5, SW 4, R-type 4, ADDI/ANDI 4, BEQ 3, J 3, illegal 3, overflow trap 4.
- RetireCount changes on the edge that leaves the retiring state.
- Opcode and Funct are sampled in DECODE and held internally to the end of the instruction, so IR changes after DECODE are ignored.

## Structure
- Shared package `alu_pkg`:
  - 4-bit ALU code constants.
  - Opcode and funct constants.
  - ALUSrcA/ALUSrcB/PCSource encodings.
  - State enum.
- One natural sub-module, `alu_op_decode`: combinational funct/opcode → ALU code plus an is_shift flag and an is_trapping flag.

## Test plan
- Reset held 3 cycles, then released → all outputs 0 during reset; FETCH in the first cycle after release (MemRead=1, IRWrite=1, PCWrite=1, ALUCtrlOut=0001); RetireCount=0.
- Opcode 0x00, Funct 0x2A (SLT) → states FETCH, DECODE, EXEC_R (ALUCtrlOut=1001, ALUSrcA=01), RWB (RegWrite=1, RegDst=1); RetireCount=1.
- Opcode 0x00, Funct 0x03 (SRA) → EXEC_R drives ALUSrcA=10, ALUCtrlOut=1000. Then LW (opcode 0x23) → 5 cycles, MemRead and IorD in MEMRD, MemtoReg in MEMWB.
- BEQ with Zero=1, then with Zero=0 → PCWriteCond=1 and PCSource=01 in BRANCH both times; RetireCount advances by 2 in total.
- ADD (0x00/0x20) with Overflow=1 in EXEC_R → EXC with Exception=1 and PCSource=11, no RegWrite, RetireCount unchanged. With TRAP_ON_OVERFLOW=0 → RWB as normal.
- Opcode 0x3F → EXC in the third cycle. Separately, Reset asserted during MEMRD → no MemWrite/RegWrite, FETCH after release.
